// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - Op codes (3-bit, sampled with Start)
//   - FSM state encoding for the top-level sequencer
//   - Small decode helpers used by the top module
package mdu_pkg;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_MADDU = 3'b100;
  localparam logic [2:0] MDU_MADD  = 3'b101;
  localparam logic [2:0] MDU_MSUBU = 3'b110;
  localparam logic [2:0] MDU_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == MDU_MADDU) || (op == MDU_MADD) || (op == MDU_MSUBU) || (op == MDU_MSUB);
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return (op == MDU_MSUBU) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: WIDTH-step restoring divider working on unsigned magnitudes.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   load              capture dividend/divisor and clear the partial remainder
//   step              perform one shift/subtract/restore iteration
//   dividend, divisor operand magnitudes (sampled on load)
//   quotient          quotient after WIDTH steps
//   remainder         remainder after WIDTH steps
// The quotient register doubles as the dividend shift register: each step
// shifts its MSB into the partial remainder and its LSB receives the new
// quotient bit.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // shifted < 2*divisor, so a non-negative difference always fits in WIDTH
  // bits and diff[WIDTH] is a clean borrow flag.
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
    end else if (load) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_reg <= diff[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
        // restore: keep the shifted remainder, quotient bit is 0
        rem_reg <= shifted[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit.
//   Radix-2 shift-add multiplier and restoring divider (mdu_div_core) on
//   operand magnitudes; signs are applied in a final FIX cycle, which also
//   performs MADD/MSUB accumulation into {HI,LO}.
// Ports:
//   Clk, Rst     clock, synchronous active-high reset
//   D1, D2       operand A / dividend / MTHI-MTLO data, operand B / divisor
//   Op           operation code (mdu_pkg), sampled with Start
//   Start        launch an operation (ignored while Busy)
//   Abort        cancel an in-flight operation, HI/LO untouched
//   We, HiLo     direct HI (HiLo=1) or LO (HiLo=0) write while idle
//   Busy         operation in flight (WIDTH+1 cycles)
//   Done         one-cycle pulse when HI/LO hold the new result
//   DivZero      one-cycle pulse with Done for DIV/DIVU by zero
//   HI, LO       result registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit HAS_ACC = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [2:0]       Op,
  input  logic             Start,
  input  logic             Abort,
  input  logic             We,
  input  logic             HiLo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_t         state_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   b_mag_reg;
  logic               neg_q_reg;      // product / quotient sign
  logic               neg_r_reg;      // remainder sign (sign of dividend)
  logic               dz_op_reg;      // divide with zero divisor
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               div_zero_reg;

  // Operand magnitudes for launch
  logic             d1_neg;
  logic             d2_neg;
  logic [WIDTH-1:0] d1_mag;
  logic [WIDTH-1:0] d2_mag;
  logic             start_accept;

  assign d1_neg       = is_signed(Op) & D1[WIDTH-1];
  assign d2_neg       = is_signed(Op) & D2[WIDTH-1];
  assign d1_mag       = d1_neg ? -D1 : D1;
  assign d2_mag       = d2_neg ? -D2 : D2;
  assign start_accept = Start && !Abort && (state_reg == ST_IDLE);

  // Multiplier step: multiplier bits sit in the low half of prod_reg and
  // are consumed LSB first while partial sums build up in the high half.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;

  assign mul_addend = prod_reg[0] ? b_mag_reg : '0;
  assign mul_sum    = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

  // Divider
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (start_accept),
    .step     (state_reg == ST_RUN),
    .dividend (d1_mag),
    .divisor  (d2_mag),
    .quotient (quotient),
    .remainder(remainder)
  );

  // FIX-cycle result formation
  logic [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0] hilo_cur;
  logic [2*WIDTH-1:0] mul_result;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_signed = neg_q_reg ? -prod_reg : prod_reg;
  assign hilo_cur    = {hi_reg, lo_reg};
  // MIN / -1 wraps naturally: |MIN| / 1 = MIN, and -MIN == MIN.
  assign quo_fix     = neg_q_reg ? -quotient : quotient;
  assign rem_fix     = neg_r_reg ? -remainder : remainder;

  always_comb begin
    mul_result = prod_signed;
    if (HAS_ACC && is_acc(op_reg)) begin
      if (is_sub(op_reg)) begin
        mul_result = hilo_cur - prod_signed;
      end else begin
        mul_result = hilo_cur + prod_signed;
      end
    end
  end

  always_ff @(posedge Clk) begin
    done_reg     <= 1'b0;
    div_zero_reg <= 1'b0;
    if (Rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= MDU_MULTU;
      b_mag_reg <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_op_reg <= 1'b0;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
    end else if (Abort && (state_reg != ST_IDLE)) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_accept) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
            op_reg    <= Op;
            b_mag_reg <= d2_mag;
            neg_q_reg <= d1_neg ^ d2_neg;
            neg_r_reg <= d1_neg;
            dz_op_reg <= is_div(Op) && (D2 == '0);
            cnt_reg   <= CW'(WIDTH - 1);
            prod_reg  <= {{WIDTH{1'b0}}, d1_mag};
          end else if (We && !Start) begin
            if (HiLo) begin
              hi_reg <= D1;
            end else begin
              lo_reg <= D1;
            end
          end
        end
        ST_RUN: begin
          prod_reg <= {mul_sum, prod_reg[WIDTH-1:1]};
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_reg    <= ST_IDLE;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
          div_zero_reg <= dz_op_reg;
          if (is_div(op_reg)) begin
            if (!dz_op_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end
          end else begin
            {hi_reg, lo_reg} <= mul_result;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign DivZero = div_zero_reg;
  assign HI      = hi_reg;
  assign LO      = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit (WIDTH=32). u_dut has accumulate
// enabled, u_dut_nacc has HAS_ACC=0; both share the same stimulus.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        we = 1'b0;
  logic        hilo = 1'b0;

  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic        busy_n, done_n, div_zero_n;
  logic [31:0] hi_n, lo_n;

  int checks = 0;
  int errors = 0;

  int   busy_len;
  logic done_seen, dz_seen, done_after;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .HAS_ACC(1'b1)) u_dut (
    .Clk(clk), .Rst(rst), .D1(d1), .D2(d2), .Op(op), .Start(start),
    .Abort(abort), .We(we), .HiLo(hilo), .Busy(busy), .Done(done),
    .DivZero(div_zero), .HI(hi), .LO(lo)
  );

  mult_div_unit #(.WIDTH(32), .HAS_ACC(1'b0)) u_dut_nacc (
    .Clk(clk), .Rst(rst), .D1(d1), .D2(d2), .Op(op), .Start(start),
    .Abort(abort), .We(we), .HiLo(hilo), .Busy(busy_n), .Done(done_n),
    .DivZero(div_zero_n), .HI(hi_n), .LO(lo_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic write_hilo(input logic hl, input logic [31:0] data);
    we = 1'b1; hilo = hl; d1 = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles (bounded), then samples Done/DivZero and the cycle after.
  task automatic wait_done(input int already);
    int n;
    n = already;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    busy_len  = n;
    done_seen = done;
    dz_seen   = div_zero;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    launch(o, a, b);
    wait_done(0);
    $display("op %0d d1 %08h d2 %08h -> hi %08h lo %08h busy %0d dz %0b",
             o, a, b, hi, lo, busy_len, dz_seen);
    check({tag, " busy_len"}, 64'(busy_len), 64'd33);
    check({tag, " done"}, 64'(done_seen), 64'd1);
    check({tag, " divzero"}, 64'(dz_seen), 64'(exp_dz));
    check({tag, " done_once"}, 64'(done_after), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    logic done_any;

    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset divzero", 64'(div_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div min", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    write_hilo(1'b1, 32'h11);
    write_hilo(1'b0, 32'h22);
    check("we hi", 64'(hi), 64'h11);
    check("we lo", 64'(lo), 64'h22);
    run_op("divu zero", MDU_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1);

    write_hilo(1'b1, 32'h0);
    write_hilo(1'b0, 32'hFFFF_FFFF);
    run_op("maddu", MDU_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 1'b0);

    write_hilo(1'b1, 32'h0);
    write_hilo(1'b0, 32'h0);
    run_op("msub", MDU_MSUB, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    write_hilo(1'b1, 32'h0);
    write_hilo(1'b0, 32'd10);
    run_op("madd", MDU_MADD, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

    // Accumulate disabled: MADDU behaves as MULTU
    write_hilo(1'b1, 32'h9);
    write_hilo(1'b0, 32'h9);
    launch(MDU_MADDU, 32'd2, 32'd3);
    wait_done(0);
    $display("nacc maddu 2*3 -> hi %08h lo %08h", hi_n, lo_n);
    check("nacc hi", 64'(hi_n), 64'h0);
    check("nacc lo", 64'(lo_n), 64'h6);

    // Start and We while Busy are ignored
    write_hilo(1'b1, 32'h5);
    launch(MDU_MULTU, 32'd2, 32'd3);
    op = MDU_DIVU; d1 = 32'd100; d2 = 32'd7; start = 1'b1; we = 1'b1; hilo = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    check("busy we hi", 64'(hi), 64'h5);
    wait_done(1);
    $display("busy-start test -> hi %08h lo %08h busy %0d", hi, lo, busy_len);
    check("busy start len", 64'(busy_len), 64'd33);
    check("busy start lo", 64'(lo), 64'd6);
    check("busy start hi", 64'(hi), 64'd0);

    // Abort during RUN
    write_hilo(1'b1, 32'hAA);
    write_hilo(1'b0, 32'hBB);
    launch(MDU_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("abort -> busy %0b hi %08h lo %08h", busy, hi, lo);
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'hAA);
    check("abort lo", 64'(lo), 64'hBB);
    done_any = done;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_any = done_any | done;
    end
    check("abort no done", 64'(done_any), 64'd0);
    check("abort hi later", 64'(hi), 64'hAA);

    // Abort and Start together in IDLE: Start dropped
    op = MDU_MULTU; d1 = 32'd2; d2 = 32'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    $display("abort+start -> busy %0b", busy);
    check("abort start busy", 64'(busy), 64'd0);

    // Start and We together: Start wins, no write
    write_hilo(1'b1, 32'h99);
    op = MDU_MULTU; d1 = 32'd7; d2 = 32'd2; start = 1'b1; we = 1'b1; hilo = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    check("start we busy", 64'(busy), 64'd1);
    check("start we hi", 64'(hi), 64'h99);
    wait_done(1);
    $display("start+we -> hi %08h lo %08h", hi, lo);
    check("start we lo", 64'(lo), 64'd14);
    check("start we hi res", 64'(hi), 64'd0);

    // Reset mid-operation
    launch(MDU_MULT, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset mid-op -> busy %0b hi %08h lo %08h", busy, hi, lo);
    check("rst busy", 64'(busy), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    done_any = done;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_any = done_any | done;
    end
    check("rst no done", 64'(done_any), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
